// File: rtl/ce_pulse_driver_pkg.sv
// Shared constants and elaboration-time helpers for the clock-enable pulse driver.
package ce_pulse_driver_pkg;

  localparam int MAX_PIPELINE_REGS = 8;

  function automatic int clip_regs(input int pipeline_regs);
    if (pipeline_regs > MAX_PIPELINE_REGS) begin
      return MAX_PIPELINE_REGS;
    end
    if (pipeline_regs < 0) begin
      return 0;
    end
    return pipeline_regs;
  endfunction

  // Stage j sits j registers from the output, so it must hold what the
  // counter tap would have produced j+1 sysce cycles before phase zero.
  function automatic logic preload(input int j, input int period);
    return ((j + 1) % period) == 0;
  endfunction

  function automatic int counter_width(input int log_2_period);
    return (log_2_period < 1) ? 1 : log_2_period;
  endfunction

endpackage

// File: rtl/ce_pulse_driver_delay_reg.sv
// One-bit enable register with asynchronous clear to a parameterised value.
module enable_delay_reg #(
  parameter bit init_value = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= init_value;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ce_pulse_driver.sv
// Rate-domain clock-enable generator: passes clock/clear through and emits
// two identical 1-in-period enable pulse trains from a pre-pipelined tap.
module ce_pulse_driver
  import ce_pulse_driver_pkg::*;
#(
  parameter int log_2_period  = 1,
  parameter int period        = 2,
  parameter int use_bufg      = 0,
  parameter int pipeline_regs = 5
) (
  input  logic sysclk,
  input  logic sysclr,
  input  logic sysce,
  output logic clk,
  output logic clr,
  output logic ce,
  output logic ce_logic
);

  localparam int N = clip_regs(pipeline_regs);
  localparam int W = counter_width(log_2_period);

  logic ce_int;
  logic ce_logic_int;

  assign clk = sysclk;
  assign clr = sysclr;

  generate
    if (period == 1) begin : g_full_rate
      assign ce_int       = sysce;
      assign ce_logic_int = sysce;
    end else begin : g_divided
      localparam bit POW2 = (period == (1 << W));
      localparam logic [W-1:0] TAP = W'(period - 1 - (N % period));

      logic [W-1:0] count_reg;
      logic [W-1:0] count_next;
      logic         tap_pulse;

      if (POW2) begin : g_natural_wrap
        assign count_next = count_reg + W'(1);
      end else begin : g_flag_wrap
        // Flag is registered one step early so the wrap compare stays off the
        // counter's increment path.
        logic wrap_reg;
        enable_delay_reg #(.init_value(1'b0)) u_wrap (
          .clk (sysclk),
          .clr (sysclr),
          .en  (sysce),
          .d   (count_reg == W'(period - 2)),
          .q   (wrap_reg)
        );
        assign count_next = wrap_reg ? '0 : count_reg + W'(1);
      end

      always_ff @(posedge sysclk or posedge sysclr) begin
        if (sysclr) begin
          count_reg <= '0;
        end else if (sysce) begin
          count_reg <= count_next;
        end
      end

      assign tap_pulse = (count_reg == TAP);

      if (N == 0) begin : g_no_pipe
        assign ce_int       = tap_pulse;
        assign ce_logic_int = tap_pulse;
      end else begin : g_pipe
        logic [N-1:0] ce_pipe;
        logic [N-1:0] logic_pipe;

        for (genvar gi = 0; gi < N; gi++) begin : g_stage
          localparam bit STAGE_INIT = preload(gi, period);
          logic d_ce;
          logic d_logic;

          if (gi == N - 1) begin : g_head
            assign d_ce    = tap_pulse;
            assign d_logic = tap_pulse;
          end else begin : g_body
            assign d_ce    = ce_pipe[gi+1];
            assign d_logic = logic_pipe[gi+1];
          end

          enable_delay_reg #(.init_value(STAGE_INIT)) u_ce_stage (
            .clk (sysclk),
            .clr (sysclr),
            .en  (sysce),
            .d   (d_ce),
            .q   (ce_pipe[gi])
          );

          enable_delay_reg #(.init_value(STAGE_INIT)) u_logic_stage (
            .clk (sysclk),
            .clr (sysclr),
            .en  (sysce),
            .d   (d_logic),
            .q   (logic_pipe[gi])
          );
        end

        assign ce_int       = ce_pipe[0];
        assign ce_logic_int = logic_pipe[0];
      end
    end

    // Global-buffer mode leaves the enable ungated so it can ride a clock net.
    if (use_bufg != 0) begin : g_bufg
      assign ce       = ce_int;
      assign ce_logic = ce_logic_int;
    end else begin : g_gated
      assign ce       = ce_int & sysce;
      assign ce_logic = ce_logic_int & sysce;
    end
  endgenerate

endmodule

// File: tb/tb_ce_pulse_driver.sv
// Scoreboard bench: directed sysce/sysclr vectors with hand-computed ce patterns.
`timescale 1ns/1ps
module tb_ce_pulse_driver;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic [3:0] sysclr_v = 4'hF;
  logic [3:0] sysce_v  = 4'h0;
  logic [3:0] clk_v, clr_v, ce_v, cel_v;

  ce_pulse_driver #(.log_2_period(2), .period(4), .use_bufg(0), .pipeline_regs(5)) dut0 (
    .sysclk(sysclk), .sysclr(sysclr_v[0]), .sysce(sysce_v[0]),
    .clk(clk_v[0]), .clr(clr_v[0]), .ce(ce_v[0]), .ce_logic(cel_v[0]));

  ce_pulse_driver #(.log_2_period(2), .period(3), .use_bufg(0), .pipeline_regs(0)) dut1 (
    .sysclk(sysclk), .sysclr(sysclr_v[1]), .sysce(sysce_v[1]),
    .clk(clk_v[1]), .clr(clr_v[1]), .ce(ce_v[1]), .ce_logic(cel_v[1]));

  ce_pulse_driver #(.log_2_period(3), .period(5), .use_bufg(0), .pipeline_regs(12)) dut2 (
    .sysclk(sysclk), .sysclr(sysclr_v[2]), .sysce(sysce_v[2]),
    .clk(clk_v[2]), .clr(clr_v[2]), .ce(ce_v[2]), .ce_logic(cel_v[2]));

  ce_pulse_driver #(.log_2_period(1), .period(1), .use_bufg(0), .pipeline_regs(5)) dut3 (
    .sysclk(sysclk), .sysclr(sysclr_v[3]), .sysce(sysce_v[3]),
    .clk(clk_v[3]), .clr(clr_v[3]), .ce(ce_v[3]), .ce_logic(cel_v[3]));

  typedef struct {
    int   d;
    int   tid;
    int   step;
    logic exp_ce;
  } exp_t;

  exp_t sb_q[$];
  int   checks  = 0;
  int   passed  = 0;
  logic running = 1'b0;

  task automatic check(input string name, input int tid, input logic act, input logic req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s test%0d: got %b, required %b", name, tid, act, req);
  endtask

  // One vector step: inputs change 1ns after the edge, expectation queued.
  task automatic drive(input int d, input int tid, input int step,
                       input logic sce, input logic clr_in, input logic exp_ce);
    exp_t e;
    @(posedge sysclk);
    #1;
    sysce_v[d]  = sce;
    sysclr_v[d] = clr_in;
    e.d = d; e.tid = tid; e.step = step; e.exp_ce = exp_ce;
    sb_q.push_back(e);
  endtask

  task automatic run_vec(input int d, input int tid,
                         input string sce_s, input string clr_s, input string exp_s);
    for (int i = 0; i < sce_s.len(); i++) begin
      drive(d, tid, i, sce_s[i] == 8'h31, clr_s[i] == 8'h31, exp_s[i] == 8'h31);
    end
  endtask

  always @(negedge sysclk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("txn test%0d dut%0d step%0d sysce=%b sysclr=%b ce=%b ce_logic=%b expect=%b",
               e.tid, e.d, e.step, sysce_v[e.d], sysclr_v[e.d], ce_v[e.d], cel_v[e.d], e.exp_ce);
      check("ce",       e.tid, ce_v[e.d],  e.exp_ce);
      check("ce_logic", e.tid, cel_v[e.d], e.exp_ce);
      check("clk_low",  e.tid, clk_v[e.d], sysclk);
      check("clr_pass", e.tid, clr_v[e.d], sysclr_v[e.d]);
    end
  end

  always @(posedge sysclk) begin
    if (running) begin
      #2;
      check("clk_high", 0, &clk_v, 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    running = 1'b1;
    // period 4, N=5: 2 reset cycles, then pulses at k=3,7,11,15
    run_vec(0, 1, "111111111111111111", "110000000000000000", "000001000100010001");
    // period 3, N=0: pulses at k=2,5,8
    run_vec(1, 2, "11111111111", "11000000000", "00001001001");
    // period 5, N clipped to 8: pulses at k=4,9,14, none earlier
    run_vec(2, 3, "11111111111111111", "11000000000000000", "00000010000100001");
    // period 4, sysce toggling: 4th and 8th enabled cycle only
    run_vec(0, 4, "11010101010101010", "10000000000000000", "00000001000000010");
    // period 4, reset asserted during k=2 for 2 cycles, then pulses at k=3,7
    run_vec(0, 5, "1111111111111", "1001100000000", "0000000010001");
    // period 1: ce follows sysce
    run_vec(3, 6, "1011", "0000", "1011");
    repeat (2) @(posedge sysclk);
    running = 1'b0;
    #1;
    check("sb_drain", 0, sb_q.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
